// File: rtl/rect_fill_engine.sv
// Rectangle fill: clips a command to the canvas and streams one {row,col} write per pixel in raster order.
// First write appears the cycle after start; the scan advances only on wr_en && wr_ready.
module rect_fill_engine #(
  parameter int XBITS = 3,
  parameter int YBITS = 3,
  parameter int CBITS = 12
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [XBITS-1:0]       x0,
  input  logic [YBITS-1:0]       y0,
  input  logic [XBITS:0]         width,
  input  logic [YBITS:0]         height,
  input  logic [CBITS-1:0]       color,
  output logic                   busy,
  output logic                   done,
  output logic                   wr_en,
  output logic [XBITS+YBITS-1:0] wr_addr,
  output logic [CBITS-1:0]       wr_data,
  input  logic                   wr_ready
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FILL,
    S_DONE
  } state_t;

  localparam logic [XBITS:0] CANVAS_W = {1'b1, {XBITS{1'b0}}};
  localparam logic [YBITS:0] CANVAS_H = {1'b1, {YBITS{1'b0}}};

  state_t           state_q, state_d;
  logic [XBITS-1:0] x0_q, x0_d, dx_q, dx_d, wlast_q, wlast_d;
  logic [YBITS-1:0] y0_q, y0_d, dy_q, dy_d, hlast_q, hlast_d;
  logic [CBITS-1:0] color_q, color_d;

  logic [XBITS:0]   room_x, eff_w;
  logic [YBITS:0]   room_y, eff_h;

  always_comb begin
    state_d = state_q;
    x0_d    = x0_q;
    y0_d    = y0_q;
    dx_d    = dx_q;
    dy_d    = dy_q;
    wlast_d = wlast_q;
    hlast_d = hlast_q;
    color_d = color_q;

    room_x = CANVAS_W - {1'b0, x0};
    room_y = CANVAS_H - {1'b0, y0};
    eff_w  = (width < room_x) ? width : room_x;
    eff_h  = (height < room_y) ? height : room_y;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          x0_d    = x0;
          y0_d    = y0;
          color_d = color;
          dx_d    = '0;
          dy_d    = '0;
          // eff in 1..2**N, so the low bits minus one give the last index without overflow
          wlast_d = eff_w[XBITS-1:0] - XBITS'(1);
          hlast_d = eff_h[YBITS-1:0] - YBITS'(1);
          state_d = (eff_w == '0 || eff_h == '0) ? S_DONE : S_FILL;
        end
      end
      S_FILL: begin
        if (wr_ready) begin
          if (dx_q != wlast_q) begin
            dx_d = dx_q + XBITS'(1);
          end else begin
            dx_d = '0;
            if (dy_q != hlast_q) begin
              dy_d = dy_q + YBITS'(1);
            end else begin
              state_d = S_DONE;
            end
          end
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      x0_q    <= '0;
      y0_q    <= '0;
      dx_q    <= '0;
      dy_q    <= '0;
      wlast_q <= '0;
      hlast_q <= '0;
      color_q <= '0;
    end else begin
      state_q <= state_d;
      x0_q    <= x0_d;
      y0_q    <= y0_d;
      dx_q    <= dx_d;
      dy_q    <= dy_d;
      wlast_q <= wlast_d;
      hlast_q <= hlast_d;
      color_q <= color_d;
    end
  end

  // Outputs decode registered state only, so they hold steady through stalls.
  assign busy    = (state_q != S_IDLE);
  assign done    = (state_q == S_DONE);
  assign wr_en   = (state_q == S_FILL);
  assign wr_addr = {y0_q + dy_q, x0_q + dx_q};
  assign wr_data = color_q;

endmodule

// File: tb/tb_rect_fill_engine.sv
// Scoreboard bench: a raster model queues expected writes per command; a negedge monitor pops and compares.
module tb_rect_fill_engine;

  localparam int XB = 3;
  localparam int YB = 3;
  localparam int CB = 12;
  localparam int CW = 8;
  localparam int CH = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [XB-1:0] x0 = '0;
  logic [YB-1:0] y0 = '0;
  logic [XB:0]   width = '0;
  logic [YB:0]   height = '0;
  logic [CB-1:0] color = '0;
  logic          busy, done, wr_en;
  logic [XB+YB-1:0] wr_addr;
  logic [CB-1:0] wr_data;
  logic          wr_ready = 1'b1;

  always #5 clk = ~clk;

  rect_fill_engine #(.XBITS(XB), .YBITS(YB), .CBITS(CB)) dut (
    .clk(clk), .rst(rst), .start(start), .x0(x0), .y0(y0),
    .width(width), .height(height), .color(color),
    .busy(busy), .done(done), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .wr_ready(wr_ready)
  );

  typedef struct packed {
    logic [XB+YB-1:0] addr;
    logic [CB-1:0]    data;
  } wr_t;

  wr_t exp_q[$];
  bit  done_q[$];
  int  checks = 0;
  int  errors = 0;
  int  xfer_cnt = 0;
  int  ready_mode = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // Reference: clip to the canvas, then enumerate pixels row by row.
  task automatic model_cmd(input int x, input int y, input int w, input int h,
                           input logic [CB-1:0] c, output int area);
    int ew, eh;
    ew = (w < CW - x) ? w : CW - x;
    eh = (h < CH - y) ? h : CH - y;
    for (int r = 0; r < eh; r++)
      for (int col = 0; col < ew; col++)
        exp_q.push_back(wr_t'{addr: 6'((y + r) * CW + x + col), data: c});
    area = ew * eh;
    done_q.push_back(area > 0);
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #2;
      case (ready_mode)
        0: wr_ready = 1'b1;
        1: wr_ready = 1'($urandom_range(0, 1));
        default: wr_ready = 1'b0;
      endcase
    end
  end

  initial begin
    logic          prev_stall = 1'b0;
    logic          prev_rst = 1'b1;
    logic          prev_xfer = 1'b0;
    logic [XB+YB-1:0] prev_addr = '0;
    logic [CB-1:0] prev_data = '0;
    wr_t           e;
    bit            f;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (prev_stall && !prev_rst) begin
          check("stall_hold_en", 32'(wr_en), 1);
          check("stall_hold_addr", 32'(wr_addr), 32'(prev_addr));
          check("stall_hold_data", 32'(wr_data), 32'(prev_data));
        end
        if (wr_en && wr_ready) begin
          if (exp_q.size() == 0) begin
            check("spurious_write", 1, 0);
          end else begin
            e = exp_q.pop_front();
            check("wr_addr", 32'(wr_addr), 32'(e.addr));
            check("wr_data", 32'(wr_data), 32'(e.data));
          end
          xfer_cnt++;
        end
        if (done) begin
          if (done_q.size() == 0) begin
            check("spurious_done", 1, 0);
          end else begin
            f = done_q.pop_front();
            check("done_writes_drained", 32'(exp_q.size()), 0);
            if (f) check("done_after_last_xfer", 32'(prev_xfer), 1);
          end
        end
      end
      prev_stall = wr_en && !wr_ready;
      prev_addr  = wr_addr;
      prev_data  = wr_data;
      prev_xfer  = wr_en && wr_ready && !rst;
      prev_rst   = rst;
    end
  end

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 500) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("idle_timeout", 32'(busy), 0);
  endtask

  // Returns in cycle T+1 (one cycle after the accepting edge) with inputs scrambled.
  task automatic issue(input int x, input int y, input int w, input int h,
                       input logic [CB-1:0] c, output int area);
    wait_idle();
    model_cmd(x, y, w, h, c, area);
    start = 1'b1;
    x0 = XB'(x); y0 = YB'(y); width = (XB+1)'(w); height = (YB+1)'(h); color = c;
    @(posedge clk);
    #1;
    start = 1'b0;
    x0 = XB'($urandom); y0 = YB'($urandom); width = (XB+1)'($urandom);
    height = (YB+1)'($urandom); color = CB'($urandom);
    check("busy_at_T1", 32'(busy), 1);
    check("wr_en_at_T1", 32'(wr_en), 32'(area > 0));
    check("done_at_T1", 32'(done), 32'(area == 0));
  endtask

  task automatic drain(input string name);
    wait_idle();
    @(posedge clk);
    #1;
    check(name, 32'(exp_q.size()), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int area, base, n;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_wr_en", 32'(wr_en), 0);
    check("rst_wr_addr", 32'(wr_addr), 0);
    check("rst_wr_data", 32'(wr_data), 0);
    rst = 1'b0;

    // basic rectangle, then clipped corner
    ready_mode = 0;
    issue(2, 1, 3, 2, 12'hABC, area);
    drain("t1_drained");
    issue(6, 7, 4, 3, 12'h123, area);
    check("t2_area", 32'(area), 2);
    drain("t2_drained");

    // backpressure on the basic rectangle
    ready_mode = 1;
    issue(2, 1, 3, 2, 12'hABC, area);
    drain("t3_drained");

    // zero area
    ready_mode = 0;
    issue(3, 3, 0, 5, 12'h5A5, area);
    @(posedge clk);
    #1;
    check("t4_busy_T2", 32'(busy), 0);
    check("t4_done_T2", 32'(done), 0);

    // full canvas with an ignored start mid-fill
    issue(0, 0, 8, 8, 12'h0F0, area);
    repeat (10) @(posedge clk);
    #1;
    start = 1'b1; x0 = 3'd1; y0 = 3'd1; width = 4'd2; height = 4'd2; color = 12'hF0F;
    @(posedge clk);
    #1;
    start = 1'b0;
    drain("t5_drained");

    // reset while the third write is presented and stalled
    base = xfer_cnt;
    issue(2, 1, 3, 2, 12'hABC, area);
    n = 0;
    while (xfer_cnt != base + 2 && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("t6_two_writes", 32'(xfer_cnt - base), 2);
    rst = 1'b1;
    ready_mode = 2;
    @(posedge clk);
    #1;
    rst = 1'b0;
    ready_mode = 0;
    check("t6_wr_en", 32'(wr_en), 0);
    check("t6_busy", 32'(busy), 0);
    check("t6_done", 32'(done), 0);
    check("t6_pending", 32'(exp_q.size()), 4);
    exp_q.delete();
    done_q.delete();
    @(posedge clk);
    #1;
    check("t6_no_done", 32'(done), 0);
    issue(2, 1, 3, 2, 12'hABC, area);
    drain("t6_drained");

    // random commands under random backpressure
    ready_mode = 1;
    for (int i = 0; i < 20; i++) begin
      issue($urandom_range(0, CW - 1), $urandom_range(0, CH - 1),
            $urandom_range(0, 8), $urandom_range(0, 8), CB'($urandom), area);
    end
    drain("rand_drained");
    check("done_q_empty", 32'(done_q.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
